// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// block width, the payload carried between pipeline stages, and a block-generate helper.
package cla_pkg;

    localparam int CLA_BLK   = 4;
    localparam int CLA_MAX_W = 64;

    // Bits a stage has already resolved live in res. Bits it has not reached yet live in x and y.
    // carry is the carry into the next unresolved group.
    typedef struct packed {
        logic [CLA_MAX_W-1:0] res;
        logic [CLA_MAX_W-1:0] x;
        logic [CLA_MAX_W-1:0] y;
        logic                 carry;
        logic                 sub;
        logic                 v;
    } cla_payload_t;

    function automatic logic cla_block_g(input logic [CLA_BLK-1:0] g, input logic [CLA_BLK-1:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla_stage.sv
// Combinational lookahead over one group of 4-bit CLA blocks.
// Produces the group sum, the group carry-out and the carry into the group's top bit.
module cla_stage
    import cla_pkg::*;
#(
    parameter int NBLK = 1
)
(
    input  logic [NBLK*CLA_BLK-1:0] x,
    input  logic [NBLK*CLA_BLK-1:0] y,
    input  logic                    cin,
    output logic [NBLK*CLA_BLK-1:0] sum,
    output logic                    cout,
    output logic                    c_msb
);

    localparam int GW = NBLK * CLA_BLK;

    logic [GW-1:0]      gen;
    logic [GW-1:0]      prop;
    logic [GW:0]        c;
    logic [CLA_BLK-1:0] blk_g;
    logic [CLA_BLK-1:0] blk_p;
    logic               blk_c;

    assign gen  = x & y;
    assign prop = x ^ y;

    // Each block's carry-out comes straight from its block generate/propagate.
    // Carries inside a block are expanded two-level lookahead terms.
    always_comb begin
        c     = '0;
        blk_g = '0;
        blk_p = '0;
        blk_c = 1'b0;
        c[0]  = cin;
        for (int b = 0; b < NBLK; b++) begin
            blk_g = gen[b*CLA_BLK +: CLA_BLK];
            blk_p = prop[b*CLA_BLK +: CLA_BLK];
            blk_c = c[b*CLA_BLK];
            c[b*CLA_BLK+1] = blk_g[0] | (blk_p[0] & blk_c);
            c[b*CLA_BLK+2] = blk_g[1] | (blk_p[1] & blk_g[0]) | (blk_p[1] & blk_p[0] & blk_c);
            c[b*CLA_BLK+3] = blk_g[2] | (blk_p[2] & blk_g[1]) | ((&blk_p[2:1]) & blk_g[0])
                           | ((&blk_p[2:0]) & blk_c);
            c[b*CLA_BLK+4] = cla_block_g(blk_g, blk_p) | ((&blk_p) & blk_c);
        end
    end

    assign sum   = prop ^ c[GW-1:0];
    assign cout  = c[GW];
    assign c_msb = c[GW-1];

endmodule

// File: rtl/cla_add_sub_pipe.sv
// Pipelined W-bit adder/subtractor built from 4-bit CLA blocks, resolved LSB group first.
// It has a valid/ready handshake on both sides and one global stall.
module cla_add_sub_pipe
    import cla_pkg::*;
#(
    parameter int W      = 16,
    parameter int STAGES = 2
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         cin,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         cout,
    output logic         v
);

    localparam int NBLK = W / CLA_BLK;
    localparam int BPS  = NBLK / STAGES;
    localparam int GW   = BPS * CLA_BLK;

    if (W < CLA_BLK || (W % CLA_BLK) != 0 || W > CLA_MAX_W || STAGES < 1 ||
        STAGES > NBLK || (NBLK % STAGES) != 0) begin : g_bad_params
        $error("cla_add_sub_pipe: illegal W=%0d STAGES=%0d", W, STAGES);
    end

    cla_payload_t      in_pl;
    cla_payload_t      src  [1:STAGES];
    cla_payload_t      nxt  [1:STAGES];
    cla_payload_t      pipe [1:STAGES];
    logic [STAGES:1]   vld;
    logic              advance;
    logic [GW-1:0]     grp_x    [1:STAGES];
    logic [GW-1:0]     grp_y    [1:STAGES];
    logic [GW-1:0]     grp_sum  [1:STAGES];
    logic              grp_cout [1:STAGES];
    logic              grp_cmsb [1:STAGES];

    // Subtraction is x + ~y with carry-in flipped, so cin acts as a borrow-in.
    always_comb begin
        in_pl         = '0;
        in_pl.x[W-1:0] = x;
        in_pl.y[W-1:0] = y;
        in_pl.carry   = cin ^ sub;
        in_pl.sub     = sub;
    end

    always_comb begin
        src[1] = in_pl;
        for (int s = 2; s <= STAGES; s++) begin
            src[s] = pipe[s-1];
        end
    end

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        assign grp_x[s] = src[s].x[(s-1)*GW +: GW];
        assign grp_y[s] = src[s].sub ? ~src[s].y[(s-1)*GW +: GW] : src[s].y[(s-1)*GW +: GW];

        cla_stage #(.NBLK(BPS)) u_stage (
            .x     (grp_x[s]),
            .y     (grp_y[s]),
            .cin   (src[s].carry),
            .sum   (grp_sum[s]),
            .cout  (grp_cout[s]),
            .c_msb (grp_cmsb[s])
        );
    end

    // Only the last stage's v matters, because its group holds bit W-1.
    always_comb begin
        for (int s = 1; s <= STAGES; s++) begin
            nxt[s]                       = src[s];
            nxt[s].res[(s-1)*GW +: GW]   = grp_sum[s];
            nxt[s].carry                 = grp_cout[s];
            nxt[s].v                     = grp_cmsb[s] ^ grp_cout[s];
        end
    end

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance || rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int s = 1; s <= STAGES; s++) begin
                pipe[s] <= '0;
            end
        end else if (advance) begin
            vld[1] <= in_valid;
            for (int s = 2; s <= STAGES; s++) begin
                vld[s] <= vld[s-1];
            end
            for (int s = 1; s <= STAGES; s++) begin
                pipe[s] <= nxt[s];
            end
        end
    end

    assign out_valid = vld[STAGES];
    assign out       = pipe[STAGES].res[W-1:0];
    assign cout      = pipe[STAGES].carry;
    assign v         = pipe[STAGES].v;

endmodule
